bcd_converter_seq: RTL and testbench

Sequential, parametrised binary-to-BCD converter with built-in seven-segment decode, using the shift-and-add-3 (double-dabble) algorithm. It converts a WIDTH-bit unsigned value into DIGITS BCD digits over WIDTH clock cycles, controlled by a start/busy/done handshake. The result stays held on registered BCD and HEX outputs for direct connection to the board's seven-segment displays. It replaces the fixed 4-bit, two-digit combinational converter for all wider display paths.

---
 rtl/bcd_converter_seq.sv | 141 ++++++++++++++
 tb/tb_bcd_converter_seq.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/bcd_converter_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3) with a registered BCD
// result and a combinational active-low seven-segment decode of that result.
// A start/busy/done handshake runs one conversion over WIDTH shift cycles.
module bcd_converter_seq #(
   parameter int WIDTH    = 8,
   parameter int DIGITS   = 3,
   parameter bit BLANK_LZ = 1'b0
) (
   input  logic                  clock,
   input  logic                  resetn,
   input  logic                  start,
   input  logic [WIDTH-1:0]      bin,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd,
   output logic [7*DIGITS-1:0]   hex
);

   localparam int AW = 4 * DIGITS;
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] sh_q, sh_d;
   logic [AW-1:0]    acc_q, acc_d;
   logic [AW-1:0]    acc_adj, acc_shift;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [AW-1:0]    bcd_q, bcd_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             higher_zero;

   // Active-low segment pattern for one BCD digit, bit order a(0)..g(6).
   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'd0:    seg7 = 7'b1000000;
         4'd1:    seg7 = 7'b1111001;
         4'd2:    seg7 = 7'b0100100;
         4'd3:    seg7 = 7'b0110000;
         4'd4:    seg7 = 7'b0011001;
         4'd5:    seg7 = 7'b0010010;
         4'd6:    seg7 = 7'b0000010;
         4'd7:    seg7 = 7'b1111000;
         4'd8:    seg7 = 7'b0000000;
         4'd9:    seg7 = 7'b0010000;
         default: seg7 = 7'b1111111;
      endcase
   endfunction

   // Add-3 correction per digit (no inter-digit carry), then shift in the next binary MSB.
   always_comb begin
      acc_adj = acc_q;
      for (int i = 0; i < DIGITS; i++) begin
         if (acc_q[4*i +: 4] >= 4'd5) begin
            acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
         end
      end
      acc_shift = {acc_adj[AW-2:0], sh_q[WIDTH-1]};
   end

   // Next-state and datapath control for the IDLE/SHIFT handshake.
   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latch).
      state_d = state_q;
      sh_d    = sh_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      bcd_d   = bcd_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = SHIFT;
               sh_d    = bin;
               acc_d   = '0;
               cnt_d   = CW'(WIDTH);
               busy_d  = 1'b1;
            end
         end
         SHIFT: begin
            acc_d = acc_shift;
            sh_d  = sh_q << 1;
            cnt_d = cnt_q - CW'(1);
            // Last iteration: publish the shifted accumulator and hand back to IDLE.
            if (cnt_q == CW'(1)) begin
               bcd_d   = acc_shift;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers; reset aborts any conversion in flight.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q <= IDLE;
         sh_q    <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         bcd_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state_q <= state_d;
         sh_q    <= sh_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         bcd_q   <= bcd_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // Seven-segment decode of the held result, with optional leading-zero blanking.
   always_comb begin
      hex         = '1;
      higher_zero = 1'b1;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         higher_zero = higher_zero && (bcd_q[4*i +: 4] == 4'd0);
         if (BLANK_LZ && (i > 0) && higher_zero) begin
            hex[7*i +: 7] = 7'b1111111;
         end else begin
            hex[7*i +: 7] = seg7(bcd_q[4*i +: 4]);
         end
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign bcd  = bcd_q;

endmodule

// File: tb/tb_bcd_converter_seq.sv
// Testbench for bcd_converter_seq: three instances (8-bit/3-digit, the same
// with leading-zero blanking, 16-bit/5-digit) checked against a decimal model.
module tb_bcd_converter_seq;

   logic             clock;
   logic             resetn;
   logic [2:0]       start_v;
   logic [2:0][15:0] bin_v;
   logic [2:0]       busy_v;
   logic [2:0]       done_v;
   logic [2:0][19:0] bcd_v;
   logic [2:0][34:0] hex_v;

   logic [11:0] bcd0, bcd1;
   logic [19:0] bcd2;
   logic [20:0] hex0, hex1;
   logic [34:0] hex2;

   int checks   = 0;
   int failures = 0;

   bcd_converter_seq #(.WIDTH(8), .DIGITS(3), .BLANK_LZ(1'b0)) dut0 (
      .clock(clock), .resetn(resetn), .start(start_v[0]), .bin(bin_v[0][7:0]),
      .busy(busy_v[0]), .done(done_v[0]), .bcd(bcd0), .hex(hex0));

   bcd_converter_seq #(.WIDTH(8), .DIGITS(3), .BLANK_LZ(1'b1)) dut1 (
      .clock(clock), .resetn(resetn), .start(start_v[1]), .bin(bin_v[1][7:0]),
      .busy(busy_v[1]), .done(done_v[1]), .bcd(bcd1), .hex(hex1));

   bcd_converter_seq #(.WIDTH(16), .DIGITS(5), .BLANK_LZ(1'b0)) dut2 (
      .clock(clock), .resetn(resetn), .start(start_v[2]), .bin(bin_v[2]),
      .busy(busy_v[2]), .done(done_v[2]), .bcd(bcd2), .hex(hex2));

   assign bcd_v[0] = {8'b0, bcd0};
   assign bcd_v[1] = {8'b0, bcd1};
   assign bcd_v[2] = bcd2;
   assign hex_v[0] = {14'b0, hex0};
   assign hex_v[1] = {14'b0, hex1};
   assign hex_v[2] = hex2;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: decimal digits of val packed 4 bits each.
   function automatic logic [63:0] ref_bcd(input int val, input int digits);
      logic [63:0] r = '0;
      int p = 1;
      for (int i = 0; i < digits; i++) begin
         r[4*i +: 4] = 4'((val / p) % 10);
         p = p * 10;
      end
      return r;
   endfunction

   // Reference: active-low segments per decimal digit, blanking digits above the number's length.
   function automatic logic [63:0] ref_hex(input int val, input int digits, input bit blank);
      logic [6:0] tbl [10];
      logic [63:0] r = '0;
      int p = 1;
      tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
              7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
      for (int i = 0; i < digits; i++) begin
         if (blank && i > 0 && val < p) r[7*i +: 7] = 7'b1111111;
         else                           r[7*i +: 7] = tbl[(val / p) % 10];
         p = p * 10;
      end
      return r;
   endfunction

   function automatic int width_of(input int d);
      return (d == 2) ? 16 : 8;
   endfunction

   function automatic int digits_of(input int d);
      return (d == 2) ? 5 : 3;
   endfunction

   // Count rising edges (sampled 1 time unit after each) until done, bounded.
   task automatic wait_done(input int d, output int n, output bit busy_ok);
      n = 0;
      busy_ok = 1'b1;
      while (!done_v[d] && n < 40) begin
         if (!busy_v[d]) busy_ok = 1'b0;
         @(posedge clock); #1;
         n++;
      end
   endtask

   // One full conversion on instance d with latency, busy, result and pulse-width checks.
   task automatic run(input int d, input int val, input string tag);
      int n;
      bit busy_ok;
      @(posedge clock); #1;
      start_v[d] = 1'b1;
      bin_v[d]   = 16'(val);
      @(posedge clock); #1;
      start_v[d] = 1'b0;
      bin_v[d]   = 16'hFFFF;
      wait_done(d, n, busy_ok);
      check({tag, ".latency"}, 64'(n), 64'(width_of(d)));
      check({tag, ".busy_during"}, 64'(busy_ok), 64'd1);
      check({tag, ".busy_at_done"}, 64'(busy_v[d]), 64'd0);
      check({tag, ".bcd"}, 64'(bcd_v[d]), ref_bcd(val, digits_of(d)));
      check({tag, ".hex"}, 64'(hex_v[d]), ref_hex(val, digits_of(d), d == 1));
      @(posedge clock); #1;
      check({tag, ".done_pulse"}, 64'(done_v[d]), 64'd0);
   endtask

   initial begin
      int n, n2, v;
      bit busy_ok, done_seen;
      int boundary [5];

      resetn  = 1'b0;
      start_v = '0;
      bin_v   = '0;
      repeat (3) @(negedge clock);
      resetn = 1'b1;
      #1;

      // Reset values on every instance.
      for (int d = 0; d < 3; d++) begin
         check($sformatf("reset%0d.busy", d), 64'(busy_v[d]), 64'd0);
         check($sformatf("reset%0d.done", d), 64'(done_v[d]), 64'd0);
         check($sformatf("reset%0d.bcd", d), 64'(bcd_v[d]), 64'd0);
      end
      check("reset0.hex", 64'(hex_v[0]), 64'({7'b1000000, 7'b1000000, 7'b1000000}));
      check("reset1.hex", 64'(hex_v[1]), 64'({7'b1111111, 7'b1111111, 7'b1000000}));
      check("reset2.hex", 64'(hex_v[2]), {29'b0, {5{7'b1000000}}});

      // bin=255 with explicit segment patterns.
      run(0, 255, "w8_255");
      check("w8_255.bcd_const", 64'(bcd_v[0]), 64'h255);
      check("w8_255.hex_const", 64'(hex_v[0]), 64'({7'b0100100, 7'b0010010, 7'b0010010}));

      // Boundary values.
      boundary = '{0, 9, 10, 99, 100};
      foreach (boundary[i]) run(0, boundary[i], $sformatf("w8_b%0d", boundary[i]));

      // Leading-zero blanking.
      run(1, 7, "blank_7");
      check("blank_7.hex_const", 64'(hex_v[1]), 64'({7'b1111111, 7'b1111111, 7'b1111000}));
      run(1, 0, "blank_0");
      check("blank_0.hex_const", 64'(hex_v[1]), 64'({7'b1111111, 7'b1111111, 7'b1000000}));
      run(1, 205, "blank_205");

      // Start while busy is ignored; start in the done cycle is accepted.
      @(posedge clock); #1;
      start_v[0] = 1'b1; bin_v[0] = 16'd42;
      @(posedge clock); #1;
      start_v[0] = 1'b0; bin_v[0] = 16'd0;
      repeat (3) begin @(posedge clock); #1; end
      start_v[0] = 1'b1; bin_v[0] = 16'd99;
      @(posedge clock); #1;
      start_v[0] = 1'b0; bin_v[0] = 16'd0;
      wait_done(0, n, busy_ok);
      check("ignore.latency", 64'(4 + n), 64'd8);
      check("ignore.bcd", 64'(bcd_v[0]), 64'h042);
      start_v[0] = 1'b1; bin_v[0] = 16'd99;
      @(posedge clock); #1;
      start_v[0] = 1'b0; bin_v[0] = 16'd0;
      check("donecyc.busy", 64'(busy_v[0]), 64'd1);
      wait_done(0, n2, busy_ok);
      check("donecyc.latency", 64'(n2), 64'd8);
      check("donecyc.bcd", 64'(bcd_v[0]), 64'h099);

      // Reset in the middle of a conversion.
      @(posedge clock); #1;
      start_v[0] = 1'b1; bin_v[0] = 16'd200;
      @(posedge clock); #1;
      start_v[0] = 1'b0;
      repeat (4) begin @(posedge clock); #1; end
      resetn = 1'b0;
      #1;
      check("midrst.busy", 64'(busy_v[0]), 64'd0);
      check("midrst.done", 64'(done_v[0]), 64'd0);
      check("midrst.bcd", 64'(bcd_v[0]), 64'd0);
      check("midrst.hex", 64'(hex_v[0]), 64'({7'b1000000, 7'b1000000, 7'b1000000}));
      @(negedge clock);
      @(negedge clock);
      resetn = 1'b1;
      done_seen = 1'b0;
      repeat (12) begin
         @(posedge clock); #1;
         if (done_v[0]) done_seen = 1'b1;
      end
      check("midrst.no_done", 64'(done_seen), 64'd0);
      run(0, 200, "midrst.restart");

      // Wide instance: full scale, then random values against the decimal model.
      run(2, 65535, "w16_max");
      check("w16_max.bcd_const", 64'(bcd_v[2]), 64'h65535);
      for (int k = 0; k < 1000; k++) begin
         v = int'($urandom_range(65535, 0));
         run(2, v, $sformatf("w16_rnd%0d_%0d", k, v));
      end
      for (int k = 0; k < 50; k++) begin
         v = int'($urandom_range(255, 0));
         run(0, v, $sformatf("w8_rnd%0d_%0d", k, v));
         run(1, v, $sformatf("blank_rnd%0d_%0d", k, v));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
